// File: rtl/serpent_round_ctrl.sv
// Iterative Serpent round sequencer: loads a block, steps an external round datapath ROUNDS times, then holds the result.
// Optional decrypt ordering (reversed round/subkey index, o_first marker) is enabled by defining SERPENT_ROUND_CTRL_DECRYPT_EN.
module serpent_round_ctrl #(
    parameter int ROUNDS = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [127:0] i_data,
    output logic [127:0] o_rnd_data,
    output logic [5:0]   o_round,
    output logic [5:0]   o_sk_idx,
    output logic         o_last,
    input  logic [127:0] i_rnd_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [127:0] o_data,
    output logic         o_busy
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
    ,
    input  logic         i_decrypt,
    output logic         o_first
`endif
);

    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state_q;
    logic [127:0] data_q;
    logic [5:0]   step_q;
    logic [5:0]   round_q;
    logic         last_q;
    logic         valid_q;
    logic         ready_q;
    logic         busy_q;
    logic [5:0]   step_d;
    logic         dec_acc;
    logic         mode_now;

    assign step_d = step_q + 6'd1;

`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
    logic mode_q;
    logic first_q;
    assign dec_acc  = i_decrypt;
    assign mode_now = mode_q;
    assign o_first  = first_q;
`else
    assign dec_acc  = 1'b0;
    assign mode_now = 1'b0;
`endif

    // All port-visible controls are registered; the next-cycle values are chosen
    // alongside the state transition so they line up with the step being run.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            step_q  <= '0;
            round_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
            mode_q  <= 1'b0;
            first_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        state_q <= RUN;
                        data_q  <= i_data;
                        step_q  <= '0;
                        round_q <= dec_acc ? LAST : 6'd0;
                        last_q  <= (LAST == 6'd0);
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
                        mode_q  <= i_decrypt;
                        first_q <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    data_q <= i_rnd_data;
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
                    first_q <= 1'b0;
`endif
                    if (step_q == LAST) begin
                        state_q <= DONE;
                        step_q  <= '0;
                        round_q <= '0;
                        last_q  <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        step_q  <= step_d;
                        round_q <= mode_now ? (LAST - step_d) : step_d;
                        last_q  <= (step_d == LAST);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_ready    = ready_q;
    assign o_rnd_data = data_q;
    assign o_data     = data_q;
    assign o_round    = round_q;
    assign o_sk_idx   = round_q;
    assign o_last     = last_q;
    assign o_valid    = valid_q;
    assign o_busy     = busy_q;

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Self-checking bench for serpent_round_ctrl with a stub round datapath and an iterative reference model.
// Define SERPENT_ROUND_CTRL_DECRYPT_EN to also exercise decrypt ordering.
module tb_serpent_round_ctrl;

    localparam int ROUNDS = 32;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         inValid = 1'b0;
    logic         inReady = 1'b1;
    logic [127:0] inData = '0;
    logic         outReady;
    logic         outValid;
    logic         outBusy;
    logic         outLast;
    logic [127:0] rndOut;
    logic [127:0] rndIn;
    logic [127:0] outData;
    logic [5:0]   outRound;
    logic [5:0]   outSkIdx;
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
    logic         inDecrypt = 1'b0;
    logic         outFirst;
`endif

    int stubMode = 0;
    int total = 0;
    int bad = 0;
    int acceptCount = 0;
    int cycle = 0;
    int acceptCycles[$];
    logic [127:0] resultQ[$];

    always #5 clock = ~clock;

    serpent_round_ctrl #(.ROUNDS(ROUNDS)) dut (
        .i_clk      (clock),
        .i_rst      (reset),
        .i_valid    (inValid),
        .o_ready    (outReady),
        .i_data     (inData),
        .o_rnd_data (rndOut),
        .o_round    (outRound),
        .o_sk_idx   (outSkIdx),
        .o_last     (outLast),
        .i_rnd_data (rndIn),
        .o_valid    (outValid),
        .i_ready    (inReady),
        .o_data     (outData),
        .o_busy     (outBusy)
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
        ,
        .i_decrypt  (inDecrypt),
        .o_first    (outFirst)
`endif
    );

    // One round of the stub datapath; the reference model reuses it as a pure function.
    function automatic logic [127:0] roundFn(input logic [127:0] x, input int r, input int mode);
        logic [127:0] rv;
        rv = 128'(r);
        case (mode)
            0:       return x + 128'd1;
            1:       return x ^ rv;
            default: return ({x[126:0], x[127]} ^ (rv * 128'h9E3779B97F4A7C15)) + rv;
        endcase
    endfunction

    assign rndIn = roundFn(rndOut, int'(outRound), stubMode);

    function automatic logic [127:0] refModel(input logic [127:0] din, input bit dec, input int mode);
        logic [127:0] x;
        x = din;
        for (int r = 0; r < ROUNDS; r++)
            x = roundFn(x, dec ? (ROUNDS - 1 - r) : r, mode);
        return x;
    endfunction

    always @(posedge clock) begin
        cycle <= cycle + 1;
        if (!reset && inValid && outReady) begin
            acceptCount <= acceptCount + 1;
            acceptCycles.push_back(cycle);
        end
        if (!reset && outValid && inReady)
            resultQ.push_back(outData);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Accepts one block and walks it through RUN, checking the per-round controls; returns sitting in DONE.
    task automatic runBlock(input logic [127:0] din, input bit dec, input bit noise);
        int guard;
        guard = 0;
        while (!outReady && guard < 100) begin
            tick();
            guard++;
        end
        check("ready_before_accept", outReady, 1);
        inValid = 1'b1;
        inData  = din;
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
        inDecrypt = dec;
`endif
        tick();
        inValid = 1'b0;
        for (int k = 0; k < ROUNDS; k++) begin
            check("round", outRound, dec ? (ROUNDS - 1 - k) : k);
            check("sk_idx", outSkIdx, dec ? (ROUNDS - 1 - k) : k);
            check("last", outLast, (k == ROUNDS - 1));
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
            check("first", outFirst, (k == 0));
`endif
            check("valid_in_run", outValid, 0);
            check("busy_in_run", outBusy, 1);
            if (noise) begin
                inValid = 1'($urandom);
                inData  = {4{$urandom}};
            end
            tick();
        end
        inValid = 1'b0;
        check("valid_after_32", outValid, 1);
        check("ready_in_done", outReady, 0);
        check("last_in_done", outLast, 0);
        check("round_in_done", outRound, 0);
    endtask

    initial begin
        logic [127:0] hold;
        logic [127:0] din;
        bit           dec;
        int           startCount;
        int           guard;
        bit           sawValid;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready", outReady, 1);
        check("rst_valid", outValid, 0);
        check("rst_busy", outBusy, 0);
        check("rst_round", outRound, 0);
        check("rst_sk_idx", outSkIdx, 0);
        check("rst_last", outLast, 0);
        check("rst_data", outData, 0);

        // Increment stub, latency and single-cycle valid
        stubMode = 0;
        inReady  = 1'b1;
        runBlock(128'd0, 1'b0, 1'b0);
        check("inc_data", outData, 128'h20);
        tick();
        check("valid_one_cycle", outValid, 0);
        check("ready_after_done", outReady, 1);

        // XOR-of-round stub
        stubMode = 1;
        runBlock(128'd0, 1'b0, 1'b0);
        check("xor_data", outData, 128'h0);
        tick();

        // Backpressure with input noise in RUN and DONE
        stubMode   = 0;
        inReady    = 1'b0;
        startCount = acceptCount;
        runBlock(128'h5, 1'b0, 1'b1);
        hold = outData;
        check("bp_data", outData, 128'h25);
        for (int i = 0; i < 10; i++) begin
            inValid = 1'($urandom);
            inData  = {4{$urandom}};
            check("bp_valid", outValid, 1);
            check("bp_data_stable", outData, hold);
            check("bp_ready", outReady, 0);
            tick();
        end
        inValid = 1'b0;
        check("bp_accepts", acceptCount - startCount, 1);
        inReady = 1'b1;
        tick();
        check("bp_release", outValid, 0);

        // Reset in the middle of RUN
        inValid = 1'b1;
        inData  = 128'hABC;
        tick();
        inValid = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("mid_round15", outRound, 15);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", outReady, 1);
        check("mid_rst_busy", outBusy, 0);
        check("mid_rst_valid", outValid, 0);
        check("mid_rst_data", outData, 0);

        // Reset and valid together: block must not be taken
        startCount = acceptCount;
        reset   = 1'b1;
        inValid = 1'b1;
        tick();
        reset   = 1'b0;
        inValid = 1'b0;
        check("rst_wins_busy", outBusy, 0);
        check("rst_wins_ready", outReady, 1);
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (outValid) sawValid = 1'b1;
            tick();
        end
        check("rst_no_valid", sawValid, 0);
        check("rst_wins_accepts", acceptCount - startCount, 0);
        runBlock(128'd0, 1'b0, 1'b0);
        check("post_rst_data", outData, 128'h20);
        tick();

        // Back-to-back accepts with valid held high
        acceptCycles.delete();
        resultQ.delete();
        startCount = acceptCount;
        inValid = 1'b1;
        inData  = 128'h10;
        tick();
        inData  = 128'h100;
        guard   = 0;
        while (acceptCount - startCount < 2 && guard < 80) begin
            tick();
            guard++;
        end
        inValid = 1'b0;
        guard   = 0;
        while (resultQ.size() < 2 && guard < 80) begin
            tick();
            guard++;
        end
        check("b2b_accepts", acceptCycles.size(), 2);
        check("b2b_results", resultQ.size(), 2);
        if (acceptCycles.size() >= 2)
            check("b2b_spacing", acceptCycles[1] - acceptCycles[0], 34);
        if (resultQ.size() >= 2) begin
            check("b2b_out0", resultQ[0], 128'h30);
            check("b2b_out1", resultQ[1], 128'h120);
        end
        tick();

`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
        // Decrypt ordering
        stubMode = 2;
        din = {4{$urandom}};
        runBlock(din, 1'b1, 1'b0);
        check("dec_data", outData, refModel(din, 1'b1, 2));
        tick();
`endif

        // Randomised blocks against the reference model
        stubMode = 2;
        for (int n = 0; n < 6; n++) begin
            din = {$urandom, $urandom, $urandom, $urandom};
`ifdef SERPENT_ROUND_CTRL_DECRYPT_EN
            dec = 1'($urandom);
`else
            dec = 1'b0;
`endif
            inReady = 1'b0;
            runBlock(din, dec, 1'($urandom));
            check("rand_data", outData, refModel(din, dec, 2));
            hold = outData;
            for (int h = 0; h < int'($urandom_range(0, 4)); h++) begin
                tick();
                check("rand_hold", outData, hold);
            end
            inReady = 1'b1;
            tick();
            check("rand_release", outValid, 0);
            check("rand_ready", outReady, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
